// File: rtl/affine_filter_acc.sv
// Six-tap polyphase FIR: a 16-phase coefficient table selected per sample by in_frac, with per-line window fill.
// Latency 2 cycles from acceptance to out_valid; in_ready follows !out_valid || out_ready and both stages freeze under stall.
module affine_filter_acc (
   input  logic        clk,
   input  logic        rst_n,
   input  logic        cfg_we,
   input  logic [6:0]  cfg_addr,
   input  logic [7:0]  cfg_data,
   input  logic        in_valid,
   output logic        in_ready,
   input  logic        in_sol,
   input  logic [3:0]  in_frac,
   input  logic [10:0] in_x,
   output logic        out_valid,
   input  logic        out_ready,
   output logic [15:0] out_y
);

   logic [7:0]  coef     [0:15][0:5];
   logic [10:0] win      [0:5];
   logic [10:0] win_nxt  [0:5];
   logic [18:0] prod     [0:5];
   logic [18:0] s1_prod  [0:5];
   logic [2:0]  fill;
   logic [2:0]  fill_nxt;
   logic        s1_vld;
   logic        advance;
   logic        accept;
   logic        issue;
   logic [21:0] sum;
   logic [21:0] rnd;

   // 8x11 signed multiply; the exact product always fits 19 bits
   function automatic logic [18:0] mul8x11(input logic [7:0] c, input logic [10:0] x);
      logic signed [18:0] a;
      logic signed [18:0] b;
      a = {{11{c[7]}}, c};
      b = {{8{x[10]}}, x};
      return a * b;
   endfunction

   assign advance  = !out_valid || out_ready;
   assign in_ready = rst_n && advance;
   assign accept   = in_valid && in_ready;
   assign issue    = accept && (fill_nxt == 3'd6);

   always_comb begin
      fill_nxt = fill;
      if (in_sol)
         fill_nxt = 3'd1;
      else if (fill != 3'd6)
         fill_nxt = fill + 3'd1;
   end

   // Products use the window as it will look after this sample shifts in
   always_comb begin
      for (int k = 0; k < 5; k++)
         win_nxt[k] = win[k+1];
      win_nxt[5] = in_x;
      for (int k = 0; k < 6; k++)
         prod[k] = mul8x11(coef[in_frac][k], win_nxt[k]);
   end

   always_comb begin
      sum = '0;
      for (int k = 0; k < 6; k++)
         sum = sum + {{3{s1_prod[k][18]}}, s1_prod[k]};
      rnd = sum + 22'd32;
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         for (int f = 0; f < 16; f++)
            for (int k = 0; k < 6; k++)
               coef[f][k] <= (k == 2) ? 8'd64 : 8'd0;
      end else if (cfg_we && (cfg_addr[2:0] <= 3'd5)) begin
         coef[cfg_addr[6:3]][cfg_addr[2:0]] <= cfg_data;
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         fill <= 3'd0;
         for (int k = 0; k < 6; k++)
            win[k] <= '0;
      end else if (accept) begin
         fill <= fill_nxt;
         for (int k = 0; k < 6; k++)
            win[k] <= win_nxt[k];
      end
   end

   always_ff @(posedge clk) begin
      if (!rst_n) begin
         s1_vld    <= 1'b0;
         out_valid <= 1'b0;
         out_y     <= '0;
         for (int k = 0; k < 6; k++)
            s1_prod[k] <= '0;
      end else if (advance) begin
         s1_vld <= issue;
         if (issue)
            for (int k = 0; k < 6; k++)
               s1_prod[k] <= prod[k];
         out_valid <= s1_vld;
         if (s1_vld)
            out_y <= rnd[21:6];
      end
   end

endmodule

// File: tb/tb_affine_filter_acc.sv
// Randomised and directed stimulus for affine_filter_acc, scored against a queue-based line/window model.
module tb_affine_filter_acc;

   logic        clk = 1'b0;
   logic        rst_n;
   logic        cfg_we;
   logic [6:0]  cfg_addr;
   logic [7:0]  cfg_data;
   logic        in_valid;
   logic        in_ready;
   logic        in_sol;
   logic [3:0]  in_frac;
   logic [10:0] in_x;
   logic        out_valid;
   logic        out_ready;
   logic [15:0] out_y;

   always #5 clk = ~clk;

   affine_filter_acc dut (
      .clk(clk), .rst_n(rst_n), .cfg_we(cfg_we), .cfg_addr(cfg_addr), .cfg_data(cfg_data),
      .in_valid(in_valid), .in_ready(in_ready), .in_sol(in_sol), .in_frac(in_frac), .in_x(in_x),
      .out_valid(out_valid), .out_ready(out_ready), .out_y(out_y)
   );

   int n_chk  = 0;
   int n_fail = 0;

   task automatic chk(input string tag, input int obs, input int exp);
      n_chk++;
      if (obs !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0d expected %0d", tag, obs, exp);
      end
   endtask

   logic signed [7:0] mtab [0:15][0:5];
   int hist[$];
   int expq[$];
   int accq[$];
   int cyc        = 0;
   bit nostall    = 0;
   bit prev_rst   = 0;
   bit prev_stall = 0;
   int prev_y     = 0;
   bit last_acc   = 0;

   task automatic model_reset();
      for (int f = 0; f < 16; f++)
         for (int k = 0; k < 6; k++)
            mtab[f][k] = (k == 2) ? 8'sd64 : 8'sd0;
      hist.delete();
      expq.delete();
      accq.delete();
   endtask

   // One clock: observe at the falling edge, advance the model, return just after the rising edge
   task automatic step();
      int s;
      int a;
      @(negedge clk);
      cyc++;
      last_acc = 0;
      if (!rst_n) begin
         chk("rst_in_ready", int'(in_ready), 0);
         model_reset();
         prev_rst   = 1;
         prev_stall = 0;
      end else begin
         if (prev_rst) begin
            chk("rst_out_valid", int'(out_valid), 0);
            chk("rst_out_y", int'($signed(out_y)), 0);
            chk("rel_in_ready", int'(in_ready), 1);
         end
         if (prev_stall) begin
            chk("hold_valid", int'(out_valid), 1);
            chk("hold_y", int'($signed(out_y)), prev_y);
         end
         chk("in_ready", int'(in_ready), int'(!out_valid || out_ready));
         if (out_valid && out_ready) begin
            if (expq.size() == 0) begin
               chk("spurious_out", int'($signed(out_y)), 99999);
            end else begin
               chk("out_y", int'($signed(out_y)), expq.pop_front());
               a = accq.pop_front();
               if (nostall) chk("latency", cyc - a, 2);
            end
         end
         if (in_valid && in_ready) begin
            last_acc = 1;
            if (in_sol) hist.delete();
            hist.push_back(int'($signed(in_x)));
            if (hist.size() > 6) void'(hist.pop_front());
            if (hist.size() == 6) begin
               s = 0;
               for (int k = 0; k < 6; k++) s += int'(mtab[in_frac][k]) * hist[k];
               expq.push_back((s + 32) >>> 6);
               accq.push_back(cyc);
            end
         end
         if (cfg_we && cfg_addr[2:0] < 3'd6) mtab[cfg_addr[6:3]][cfg_addr[2:0]] = cfg_data;
         prev_rst   = 0;
         prev_stall = out_valid && !out_ready;
         prev_y     = int'($signed(out_y));
      end
      @(posedge clk);
      #1;
   endtask

   task automatic send(input int x, input bit sol, input int frac);
      in_valid = 1'b1;
      in_x     = x[10:0];
      in_sol   = sol;
      in_frac  = frac[3:0];
      for (int i = 0; i < 40; i++) begin
         step();
         if (last_acc) break;
      end
      if (!last_acc) chk("accept_timeout", 0, 1);
      in_valid = 1'b0;
      in_sol   = 1'b0;
   endtask

   task automatic wr(input int f, input int t, input int d);
      cfg_we   = 1'b1;
      cfg_addr = {f[3:0], t[2:0]};
      cfg_data = d[7:0];
      step();
      cfg_we   = 1'b0;
   endtask

   task automatic idle(input int n);
      in_valid = 1'b0;
      for (int i = 0; i < n; i++) step();
   endtask

   int row5 [6] = '{1, -5, 62, 8, -3, 1};

   initial begin
      rst_n = 1'b0; cfg_we = 1'b0; cfg_addr = '0; cfg_data = '0;
      in_valid = 1'b1; in_sol = 1'b1; in_frac = '0; in_x = 11'd7; out_ready = 1'b1;
      model_reset();
      // Reset with an offered sample and a colliding coefficient write, both to be discarded
      cfg_we = 1'b1; cfg_addr = {4'd0, 3'd2}; cfg_data = 8'd0;
      for (int i = 0; i < 3; i++) step();
      cfg_we = 1'b0; in_valid = 1'b0; in_sol = 1'b0; rst_n = 1'b1;

      // Default table stream 1..10: outputs equal the middle tap, 2 cycles after the completing sample
      nostall = 1;
      for (int i = 1; i <= 10; i++) send(i, i == 1, int'($urandom_range(15)));
      idle(4);
      nostall = 0;

      // Loaded row 5 on a flat window, then a cfg write colliding with an acceptance
      for (int k = 0; k < 6; k++) wr(5, k, row5[k]);
      wr(5, 6, 99);
      wr(5, 7, 99);
      for (int i = 0; i < 6; i++) send(100, i == 0, 5);
      send(120, 0, 5);
      in_valid = 1'b1; in_x = 11'd50; in_frac = 4'd5; cfg_we = 1'b1;
      cfg_addr = {4'd5, 3'd5}; cfg_data = 8'd40;
      step();
      cfg_we = 1'b0;
      send(60, 0, 5);
      send(70, 0, 5);
      idle(4);

      // Four-cycle downstream stall in the middle of a continuous stream
      for (int i = 0; i < 14; i++) begin
         in_valid  = 1'b1;
         in_sol    = (i == 0);
         in_x      = 11'($urandom_range(2047));
         in_frac   = 4'($urandom_range(15));
         out_ready = !(i >= 8 && i < 12);
         step();
      end
      in_sol = 1'b0; out_ready = 1'b1;
      idle(4);

      // New line after 8 samples: five more samples give no output
      for (int i = 0; i < 8; i++) send(i * 10, i == 0, 5);
      for (int i = 0; i < 7; i++) send(-i * 30, i == 0, 5);
      idle(4);

      // Extreme negative sum, then reset mid-stream restores the default table
      for (int k = 0; k < 6; k++) wr(0, k, 127);
      for (int i = 0; i < 7; i++) send(-1024, i == 0, 0);
      in_valid = 1'b1; in_x = 11'd5; rst_n = 1'b0;
      step();
      rst_n = 1'b1; in_valid = 1'b0;
      for (int i = 1; i <= 8; i++) send(i * 3, i == 1, 0);
      idle(4);

      // Randomised traffic including rare resets and coefficient updates
      for (int i = 0; i < 3000; i++) begin
         rst_n     = ($urandom_range(299) != 0);
         in_valid  = ($urandom_range(9) < 7);
         in_sol    = ($urandom_range(19) == 0);
         in_x      = 11'($urandom_range(2047));
         in_frac   = 4'($urandom_range(15));
         out_ready = ($urandom_range(9) < 7);
         cfg_we    = ($urandom_range(19) == 0);
         cfg_addr  = 7'($urandom_range(127));
         cfg_data  = 8'($urandom_range(255));
         step();
      end
      rst_n = 1'b1; cfg_we = 1'b0; in_sol = 1'b0; out_ready = 1'b1;
      idle(6);
      chk("drain_empty", expq.size(), 0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule

// File: doc/affine_filter_acc.md
AFFINE_FILTER_ACC -- requirements
Module: affine_filter_acc

Interface
REQ-001 SHALL have port: clk  input  1  rising-edge clock for all state.
REQ-002 SHALL have port: rst_n  input  1  reset; synchronous, active-low.
REQ-003 SHALL have port: cfg_we  input  1  coefficient write strobe.
REQ-004 SHALL have port: cfg_addr  input  7  [6:3] frac position 0..15, [2:0] tap 0..5.
REQ-005 SHALL have port: cfg_data  input  8  signed coefficient.
REQ-006 SHALL have port: in_valid  input  1  sample offered.
REQ-007 SHALL have port: in_ready  output  1  sample accepted when in_valid and in_ready are both high.
REQ-008 SHALL have port: in_sol  input  1  start of line; qualifies the accepted sample.
REQ-009 SHALL have port: in_frac  input  4  1/16 fractional position used for the window completed by this sample.
REQ-010 SHALL have port: in_x  input  11  signed sample.
REQ-011 SHALL have port: out_valid  output  1  filtered result present.
REQ-012 SHALL have port: out_ready  input  1  downstream accepts.
REQ-013 SHALL have port: out_y  output  16  signed filtered result.

Function
REQ-014 SHALL hold a 16x6 table of signed 8-bit coefficients; a write with tap field 6 or 7 SHALL be ignored.
REQ-015 SHALL hold a 6-sample window; tap0 is the oldest sample and tap5 is the newest (the accepted sample).
REQ-016 SHALL clear the window fill count to 1 on an accepted sample with in_sol=1; otherwise each accepted sample increments the count, saturating at 6.
REQ-017 SHALL issue a result into the pipeline only for an accepted sample whose post-update fill count is 6.
REQ-018 SHALL compute sum = sum over k=0..5 of coef[in_frac][k]*window[k] at full precision (22-bit signed).
REQ-019 SHALL compute out_y = (sum + 32) >>> 6 (arithmetic shift); the result fits 16 bits without saturation.
REQ-020 SHALL use a 2-stage pipeline: products registered in stage 1, then round and shift registered in stage 2; with no stall, out_valid rises 2 cycles after acceptance.
REQ-021 SHALL compute pipeline advance = !out_valid || out_ready; in_ready SHALL equal advance; both stages SHALL hold when advance=0.
REQ-022 SHALL present out_y and out_valid stable while out_valid=1 and out_ready=0.
REQ-023 SHALL NOT pass bubbles (accepted samples with fill count <6) to the output; they occupy no output slot.
REQ-024 SHALL have a coefficient write in cycle t take effect for samples accepted from cycle t+1; a sample accepted in cycle t uses the old value.
REQ-025 SHALL leave the window and count unchanged on cycles without acceptance, including in_valid=1 with in_ready=0.

Reset
REQ-026 SHALL, while rst_n=0 at a clock edge, clear out_valid, out_y, both pipeline stages, the window and the fill count to 0.
REQ-027 SHALL reset every table row to {0,0,64,0,0,0}, so out_y equals window[2].
REQ-028 SHALL hold in_ready=0 during reset and drive in_ready=1 in the first cycle after reset release.
REQ-029 SHALL discard in-flight results and cfg writes coinciding with a reset cycle, and SHALL restart line filling after reset.

Verification
REQ-030 Default table, out_ready=1, in_sol on the first sample, stream 1..10 -> first out_valid 2 cycles after sample 6, outputs 3,4,5,6,7.
REQ-031 Write row 5 = {1,-5,62,8,-3,1}, window 100,100,100,100,100,100, frac=5 -> out_y=(6400+32)>>>6=100.
REQ-032 Hold out_ready=0 for 4 cycles mid-stream -> in_ready=0 for those cycles, out_y held constant, no result lost or duplicated after release.
REQ-033 Assert in_sol mid-stream after 8 samples -> next output appears only after 5 further samples; no output mixes samples from different lines.
REQ-034 Write cfg in the same cycle as a sample acceptance -> that result uses the old coefficient and the next result uses the new one.
REQ-035 Samples -1024 at all taps with coefficients all 127 -> out_y=(-780288+32)>>>6=-12192; assert rst_n=0 mid-stream -> out_valid=0 the next cycle and the table returns to default.
